// File: rtl/adc_bram_writer_pkg.sv
// Shared constants for the ADC-to-BRAM capture engine: default geometry and FSM encoding.
package adc_bram_writer_pkg;

  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 8;
  localparam int BASE_ADDR   = 3;
  localparam int MAX_SAMPLES = (1 << ADDR_W) - BASE_ADDR;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

endpackage

// File: rtl/adc_bram_writer_trig_sync_edge.sv
// Two-flop synchronizer for an asynchronous strobe followed by a rising-edge detector.
// edge_o is high for one clk, two clk after the input is first sampled high.
module trig_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic edge_o
);

  // [0],[1] form the synchronizer; [2] holds the previous synchronized value.
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign edge_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/adc_bram_writer.sv
// Capture engine: writes decimated ADC samples into the shared BRAM from BASE_ADDR upward,
// holding stmBusy while it owns the RAM.
module adc_bram_writer
  import adc_bram_writer_pkg::*;
#(
  parameter int ADDR_W      = adc_bram_writer_pkg::ADDR_W,
  parameter int DATA_W      = adc_bram_writer_pkg::DATA_W,
  parameter int BASE_ADDR   = adc_bram_writer_pkg::BASE_ADDR,
  parameter int MAX_SAMPLES = adc_bram_writer_pkg::MAX_SAMPLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              trigMode,
  input  logic              trigIn,
  input  logic [ADDR_W-1:0] numSamples,
  input  logic [7:0]        decim,
  input  logic [DATA_W-1:0] adcData,
  input  logic              adcValid,
  output logic [ADDR_W-1:0] busBramAddr,
  output logic [DATA_W-1:0] busBramOut,
  output logic              ctrlWeBram,
  output logic              stmBusy,
  output logic              capDone,
  output logic [ADDR_W-1:0] sampleCount
);

  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(MAX_SAMPLES);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [7:0]        dec_q, dec_d;
  logic [7:0]        dcnt_q, dcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic       trig_edge;
  logic [7:0] dec_eff;
  logic       keep;

  trig_sync_edge u_trig (
    .clk     (clk),
    .rst     (rst),
    .async_i (trigIn),
    .edge_o  (trig_edge)
  );

  // decim of 0 behaves like 1; the counter marks which valid samples are kept.
  assign dec_eff = (dec_q == 8'd0) ? 8'd1 : dec_q;
  assign keep    = (dcnt_q == 8'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    dec_d   = dec_q;
    dcnt_d  = dcnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          tgt_d  = (numSamples > MAX_CNT) ? MAX_CNT : numSamples;
          dec_d  = decim;
          cnt_d  = '0;
          dcnt_d = 8'd0;
          if (numSamples == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = trigMode ? S_ARMED : S_CAPTURE;
          end
        end
      end
      S_ARMED: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (trig_edge) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (adcValid) begin
          dcnt_d = ((dcnt_q + 8'd1) >= dec_eff) ? 8'd0 : dcnt_q + 8'd1;
          if (keep) begin
            we_d   = 1'b1;
            addr_d = BASE_A + cnt_q;
            data_d = adcData;
            cnt_d  = cnt_q + 1'b1;
            if ((cnt_q + 1'b1) == tgt_q) begin
              state_d = S_DONE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      dec_q   <= 8'd0;
      dcnt_q  <= 8'd0;
      addr_q  <= BASE_A;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      dec_q   <= dec_d;
      dcnt_q  <= dcnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busBramAddr = addr_q;
  assign busBramOut  = data_q;
  assign ctrlWeBram  = we_q;
  assign stmBusy     = busy_q;
  assign capDone     = done_q;
  assign sampleCount = cnt_q;

endmodule

// File: tb/tb_adc_bram_writer.sv
// Bench for adc_bram_writer: drives captures, predicts each BRAM write into a queue,
// and checks every write plus status outputs at the end of each scenario.
module tb_adc_bram_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        trigMode = 1'b0;
  logic        trigIn = 1'b0;
  logic [11:0] numSamples = '0;
  logic [7:0]  decim = '0;
  logic [7:0]  adcData = '0;
  logic        adcValid = 1'b0;
  logic [11:0] busBramAddr;
  logic [7:0]  busBramOut;
  logic        ctrlWeBram;
  logic        stmBusy;
  logic        capDone;
  logic [11:0] sampleCount;

  logic [19:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int m_tgt, m_dec, m_k, m_v;

  adc_bram_writer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .trigMode    (trigMode),
    .trigIn      (trigIn),
    .numSamples  (numSamples),
    .decim       (decim),
    .adcData     (adcData),
    .adcValid    (adcValid),
    .busBramAddr (busBramAddr),
    .busBramOut  (busBramOut),
    .ctrlWeBram  (ctrlWeBram),
    .stmBusy     (stmBusy),
    .capDone     (capDone),
    .sampleCount (sampleCount)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // scoreboard: every write is popped and compared at the falling edge
  always @(negedge clk) begin
    if (!rst && ctrlWeBram) begin
      if (exp_q.size() == 0) begin
        chk("spurious_we", 32'(ctrlWeBram), 32'd0);
      end else begin
        chk("wr_addr_data", 32'({busBramAddr, busBramOut}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic tm, input logic [11:0] n, input logic [7:0] d);
    trigMode   = tm;
    numSamples = n;
    decim      = d;
    start      = 1'b1;
    tick();
    start = 1'b0;
    m_tgt = (n > 12'd4093) ? 4093 : int'(n);
    m_dec = (d == 8'd0) ? 1 : int'(d);
    m_k   = 0;
    m_v   = 0;
  endtask

  task automatic drive_valid(input logic [7:0] data, input bit expect_cap);
    adcValid = 1'b1;
    adcData  = data;
    if (expect_cap) begin
      if ((m_v % m_dec) == 0 && m_k < m_tgt) begin
        exp_q.push_back({12'(3 + m_k), data});
        m_k++;
      end
      m_v++;
    end
    tick();
    adcValid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && !capDone; i++) tick();
    chk(tag, 32'(capDone), 32'd1);
  endtask

  task automatic drain(input string tag);
    tick();
    tick();
    chk(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_addr",  32'(busBramAddr), 32'd3);
    chk("rst_we",    32'(ctrlWeBram),  32'd0);
    chk("rst_busy",  32'(stmBusy),     32'd0);
    chk("rst_done",  32'(capDone),     32'd0);
    chk("rst_count", 32'(sampleCount), 32'd0);
    chk("rst_data",  32'(busBramOut),  32'd0);
    rst = 1'b0;
    tick();

    // immediate capture, 4 samples back to back
    do_start(1'b0, 12'd4, 8'd1);
    chk("t1_busy", 32'(stmBusy), 32'd1);
    drive_valid(8'h10, 1'b1);
    chk("t1_lat_we", 32'(ctrlWeBram), 32'd1);
    chk("t1_lat_cnt", 32'(sampleCount), 32'd1);
    for (int i = 1; i < 4; i++) drive_valid(8'(8'h10 + i), 1'b1);
    chk("t1_done", 32'(capDone), 32'd1);
    chk("t1_count", 32'(sampleCount), 32'd4);
    chk("t1_busy_off", 32'(stmBusy), 32'd0);
    drain("t1_queue");

    // decimation by 3, re-armed from DONE, random gaps between samples
    do_start(1'b0, 12'd3, 8'd3);
    for (int i = 0; i < 9; i++) begin
      drive_valid(8'(i), 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_done("t2_done");
    chk("t2_count", 32'(sampleCount), 32'd3);
    drain("t2_queue");

    // triggered capture: samples before and within sync latency are dropped
    do_start(1'b1, 12'd3, 8'd0);
    chk("t3_armed_busy", 32'(stmBusy), 32'd1);
    for (int i = 0; i < 4; i++) drive_valid(8'(8'h80 + i), 1'b0);
    trigIn = 1'b1;
    drive_valid(8'hA0, 1'b0);
    drive_valid(8'hA1, 1'b0);
    drive_valid(8'hA2, 1'b0);
    for (int i = 3; i < 6; i++) drive_valid(8'(8'hA0 + i), 1'b1);
    wait_done("t3_done");
    chk("t3_count", 32'(sampleCount), 32'd3);
    trigIn = 1'b0;
    drain("t3_queue");

    // clamped full-RAM capture, top address reached without wrap
    do_start(1'b0, 12'hFFF, 8'd0);
    for (int i = 0; i < 4093; i++) drive_valid(8'(i * 7 + 1), 1'b1);
    chk("t4_last_addr", 32'(busBramAddr), 32'hFFF);
    chk("t4_count", 32'(sampleCount), 32'd4093);
    chk("t4_done", 32'(capDone), 32'd1);
    drive_valid(8'h55, 1'b0);
    drive_valid(8'h56, 1'b0);
    drain("t4_queue");

    // abort after 10 of 50; a mid-capture start is ignored
    do_start(1'b0, 12'd50, 8'd1);
    for (int i = 0; i < 9; i++) drive_valid(8'(8'h30 + i), 1'b1);
    start = 1'b1;
    numSamples = 12'd2;
    drive_valid(8'h39, 1'b1);
    start = 1'b0;
    abort = 1'b1;
    adcValid = 1'b1;
    adcData = 8'hEE;
    tick();
    abort = 1'b0;
    adcValid = 1'b0;
    chk("t5_busy", 32'(stmBusy), 32'd0);
    chk("t5_done", 32'(capDone), 32'd0);
    chk("t5_count", 32'(sampleCount), 32'd10);
    for (int i = 0; i < 3; i++) drive_valid(8'(8'hC0 + i), 1'b0);
    drain("t5_queue");

    // asynchronous reset mid-capture
    do_start(1'b0, 12'd20, 8'd1);
    for (int i = 0; i < 5; i++) drive_valid(8'(8'h60 + i), 1'b1);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_busy", 32'(stmBusy), 32'd0);
    chk("t6_addr", 32'(busBramAddr), 32'd3);
    chk("t6_we", 32'(ctrlWeBram), 32'd0);
    chk("t6_count", 32'(sampleCount), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // zero-length request completes at once with no writes
    do_start(1'b0, 12'd0, 8'd1);
    chk("t7_done", 32'(capDone), 32'd1);
    chk("t7_count", 32'(sampleCount), 32'd0);
    chk("t7_busy", 32'(stmBusy), 32'd0);
    for (int i = 0; i < 3; i++) drive_valid(8'(8'hD0 + i), 1'b0);
    drain("t7_queue");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
